// File: rtl/spi_seq_pkg.sv
// Shared constants, state encodings and the ADC command helper used by the
// SPI ADC scan sequencer and its register-port bus engine.
package spi_seq_pkg;

  localparam logic [2:0] REG_RXDATA  = 3'd0;
  localparam logic [2:0] REG_TXDATA  = 3'd1;
  localparam logic [2:0] REG_STATUS  = 3'd2;
  localparam logic [2:0] REG_CONTROL = 3'd3;
  localparam logic [2:0] REG_SSEL    = 3'd5;

  localparam int STAT_RRDY = 7;
  localparam int STAT_TRDY = 6;
  localparam int STAT_TMT  = 5;
  localparam int CTRL_SSO  = 10;

  localparam logic [7:0]  MCP_START  = 8'h01;
  localparam logic [7:0]  MCP_SINGLE = 8'h80;
  localparam logic [15:0] SSEL_ADC   = 16'h0001;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SEL,
    ST_SSO_ON,
    ST_TX,
    ST_POLL,
    ST_RX,
    ST_SSO_OFF,
    ST_STORE,
    ST_GAP
  } seq_state_e;

  typedef enum logic [1:0] {
    BUS_IDLE,
    BUS_ACT1,
    BUS_ACT2,
    BUS_REC
  } bus_phase_e;

  // Command byte k of the 3-byte single-ended MCP3008 conversion frame.
  function automatic logic [7:0] mcp_tx_byte(input logic [1:0] idx, input logic [2:0] ch);
    logic [7:0] b;
    case (idx)
      2'd0:    b = MCP_START;
      2'd1:    b = MCP_SINGLE | {1'b0, ch, 4'b0000};
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/spi_bus_access.sv
// Three-cycle register-port access engine: two selected cycles with the strobe
// low, then one deselected cycle that re-arms the SPI core's strobe detector.
module spi_bus_access
  import spi_seq_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_i,
  input  logic        wr_i,
  input  logic [2:0]  addr_i,
  input  logic [15:0] wdata_i,
  output logic        done_o,
  output logic [7:0]  rdata_o,
  output logic        spi_select_o,
  output logic [2:0]  spi_addr_o,
  output logic        spi_read_n_o,
  output logic        spi_write_n_o,
  output logic [15:0] spi_wdata_o,
  input  logic [15:0] spi_rdata_i
);

  bus_phase_e  phase_q, phase_d;
  logic        sel_q, sel_d;
  logic        rd_n_q, rd_n_d;
  logic        wr_n_q, wr_n_d;
  logic [2:0]  addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        done_q, done_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [7:0]  rdata_hi_unused;

  assign rdata_hi_unused = spi_rdata_i[15:8];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q <= BUS_IDLE;
      sel_q   <= 1'b0;
      rd_n_q  <= 1'b1;
      wr_n_q  <= 1'b1;
      addr_q  <= 3'd0;
      wdata_q <= 16'h0000;
      done_q  <= 1'b0;
      rdata_q <= 8'h00;
    end else begin
      phase_q <= phase_d;
      sel_q   <= sel_d;
      rd_n_q  <= rd_n_d;
      wr_n_q  <= wr_n_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    phase_d = phase_q;
    sel_d   = sel_q;
    rd_n_d  = rd_n_q;
    wr_n_d  = wr_n_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    rdata_d = rdata_q;
    case (phase_q)
      BUS_IDLE: begin
        if (req_i) begin
          sel_d   = 1'b1;
          rd_n_d  = wr_i;
          wr_n_d  = ~wr_i;
          addr_d  = addr_i;
          wdata_d = wr_i ? wdata_i : wdata_q;
          phase_d = BUS_ACT1;
        end else begin
          phase_d = BUS_IDLE;
        end
      end
      BUS_ACT1: phase_d = BUS_ACT2;
      BUS_ACT2: begin
        // The core's registered read data is valid at the edge closing this cycle.
        if (!rd_n_q) begin
          rdata_d = spi_rdata_i[7:0];
        end else begin
          rdata_d = rdata_q;
        end
        sel_d   = 1'b0;
        rd_n_d  = 1'b1;
        wr_n_d  = 1'b1;
        done_d  = 1'b1;
        phase_d = BUS_REC;
      end
      BUS_REC:  phase_d = BUS_IDLE;
      default:  phase_d = BUS_IDLE;
    endcase
  end

  assign done_o        = done_q;
  assign rdata_o       = rdata_q;
  assign spi_select_o  = sel_q;
  assign spi_addr_o    = addr_q;
  assign spi_read_n_o  = rd_n_q;
  assign spi_write_n_o = wr_n_q;
  assign spi_wdata_o   = wdata_q;

endmodule

// File: rtl/spi_adc_scan_ctrl.sv
// Round-robin MCP3008 scan sequencer driving the SPI master core register port;
// emits one {channel, 10-bit sample} strobe per completed conversion frame.
module spi_adc_scan_ctrl
  import spi_seq_pkg::*;
#(
  parameter int NUM_CH     = 8,
  parameter int GAP_CYCLES = 1000,
  parameter int POLL_LIMIT = 8192
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  output logic        spi_select,
  output logic [2:0]  spi_addr,
  output logic        spi_read_n,
  output logic        spi_write_n,
  output logic [15:0] spi_wdata,
  input  logic [15:0] spi_rdata,
  output logic        sample_valid,
  output logic [2:0]  sample_ch,
  output logic [9:0]  sample_data,
  output logic        busy,
  output logic        timeout_err
);

  localparam int PW = $clog2(POLL_LIMIT + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  seq_state_e      state_q, state_d;
  logic [2:0]      ch_q, ch_d;
  logic [1:0]      byte_q, byte_d;
  logic [PW-1:0]   poll_cnt_q, poll_cnt_d;
  logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
  logic [7:0]      rx1_q, rx1_d;
  logic [7:0]      rx2_q, rx2_d;
  logic            frame_to_q, frame_to_d;
  logic            sample_valid_q, sample_valid_d;
  logic [2:0]      sample_ch_q, sample_ch_d;
  logic [9:0]      sample_data_q, sample_data_d;
  logic            busy_q, busy_d;
  logic            timeout_q, timeout_d;
  logic            enable_q, enable_d;

  logic            req_s;
  logic            wr_s;
  logic [2:0]      addr_s;
  logic [15:0]     wdata_s;
  logic            done_s;
  logic [7:0]      rdata_s;

  spi_bus_access u_bus (
    .clk           (clk),
    .reset_n       (reset_n),
    .req_i         (req_s),
    .wr_i          (wr_s),
    .addr_i        (addr_s),
    .wdata_i       (wdata_s),
    .done_o        (done_s),
    .rdata_o       (rdata_s),
    .spi_select_o  (spi_select),
    .spi_addr_o    (spi_addr),
    .spi_read_n_o  (spi_read_n),
    .spi_write_n_o (spi_write_n),
    .spi_wdata_o   (spi_wdata),
    .spi_rdata_i   (spi_rdata)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      ch_q           <= 3'd0;
      byte_q         <= 2'd0;
      poll_cnt_q     <= '0;
      gap_cnt_q      <= '0;
      rx1_q          <= 8'h00;
      rx2_q          <= 8'h00;
      frame_to_q     <= 1'b0;
      sample_valid_q <= 1'b0;
      sample_ch_q    <= 3'd0;
      sample_data_q  <= 10'd0;
      busy_q         <= 1'b0;
      timeout_q      <= 1'b0;
      enable_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      ch_q           <= ch_d;
      byte_q         <= byte_d;
      poll_cnt_q     <= poll_cnt_d;
      gap_cnt_q      <= gap_cnt_d;
      rx1_q          <= rx1_d;
      rx2_q          <= rx2_d;
      frame_to_q     <= frame_to_d;
      sample_valid_q <= sample_valid_d;
      sample_ch_q    <= sample_ch_d;
      sample_data_q  <= sample_data_d;
      busy_q         <= busy_d;
      timeout_q      <= timeout_d;
      enable_q       <= enable_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    ch_d           = ch_q;
    byte_d         = byte_q;
    poll_cnt_d     = poll_cnt_q;
    gap_cnt_d      = gap_cnt_q;
    rx1_d          = rx1_q;
    rx2_d          = rx2_q;
    frame_to_d     = frame_to_q;
    sample_valid_d = 1'b0;
    sample_ch_d    = sample_ch_q;
    sample_data_d  = sample_data_q;
    enable_d       = enable;
    req_s          = 1'b0;
    wr_s           = 1'b0;
    addr_s         = REG_RXDATA;
    wdata_s        = 16'h0000;
    // A fresh rising edge of enable clears the sticky error; a timeout below overrides.
    if (enable && !enable_q) begin
      timeout_d = 1'b0;
    end else begin
      timeout_d = timeout_q;
    end
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_SEL;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEL: begin
        req_s   = 1'b1;
        wr_s    = 1'b1;
        addr_s  = REG_SSEL;
        wdata_s = SSEL_ADC;
        if (done_s) begin
          state_d = ST_SSO_ON;
        end else begin
          state_d = ST_SEL;
        end
      end
      ST_SSO_ON: begin
        req_s   = 1'b1;
        wr_s    = 1'b1;
        addr_s  = REG_CONTROL;
        wdata_s = 16'h0001 << CTRL_SSO;
        if (done_s) begin
          state_d    = ST_TX;
          byte_d     = 2'd0;
          frame_to_d = 1'b0;
        end else begin
          state_d = ST_SSO_ON;
        end
      end
      ST_TX: begin
        req_s   = 1'b1;
        wr_s    = 1'b1;
        addr_s  = REG_TXDATA;
        wdata_s = {8'h00, mcp_tx_byte(byte_q, ch_q)};
        if (done_s) begin
          state_d    = ST_POLL;
          poll_cnt_d = '0;
        end else begin
          state_d = ST_TX;
        end
      end
      ST_POLL: begin
        req_s  = 1'b1;
        addr_s = REG_STATUS;
        if (!done_s) begin
          state_d = ST_POLL;
        end else if (rdata_s[STAT_RRDY]) begin
          state_d = ST_RX;
        end else if (poll_cnt_q == PW'(POLL_LIMIT - 1)) begin
          state_d    = ST_SSO_OFF;
          frame_to_d = 1'b1;
          timeout_d  = 1'b1;
        end else begin
          poll_cnt_d = poll_cnt_q + 1'b1;
        end
      end
      ST_RX: begin
        req_s  = 1'b1;
        addr_s = REG_RXDATA;
        if (!done_s) begin
          state_d = ST_RX;
        end else begin
          if (byte_q == 2'd1) begin
            rx1_d = rdata_s;
          end else if (byte_q == 2'd2) begin
            rx2_d = rdata_s;
          end else begin
            rx1_d = rx1_q;
          end
          if (byte_q == 2'd2) begin
            state_d = ST_SSO_OFF;
          end else begin
            byte_d  = byte_q + 2'd1;
            state_d = ST_TX;
          end
        end
      end
      ST_SSO_OFF: begin
        req_s   = 1'b1;
        wr_s    = 1'b1;
        addr_s  = REG_CONTROL;
        wdata_s = 16'h0000;
        if (done_s) begin
          // The channel advances even when the frame timed out.
          if (ch_q == 3'(NUM_CH - 1)) begin
            ch_d = 3'd0;
          end else begin
            ch_d = ch_q + 3'd1;
          end
          gap_cnt_d = '0;
          if (frame_to_q) begin
            state_d = ST_GAP;
          end else begin
            state_d        = ST_STORE;
            sample_valid_d = 1'b1;
            sample_ch_d    = ch_q;
            sample_data_d  = {rx1_q[1:0], rx2_q};
          end
        end else begin
          state_d = ST_SSO_OFF;
        end
      end
      ST_STORE: begin
        state_d   = ST_GAP;
        gap_cnt_d = '0;
      end
      ST_GAP: begin
        if (gap_cnt_q == GW'(GAP_CYCLES - 1)) begin
          state_d = enable ? ST_SSO_ON : ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  assign sample_valid = sample_valid_q;
  assign sample_ch    = sample_ch_q;
  assign sample_data  = sample_data_q;
  assign busy         = busy_q;
  assign timeout_err  = timeout_q;

endmodule
